// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
// Register map, mode encoding and FSM states.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_CHASE  = 2'b10,
        MODE_COUNT  = 2'b11
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_PATTERN = 2'd1;
    localparam logic [1:0] ADDR_PERIOD  = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam int CTRL_MODE_LSB = 0;
    localparam int CTRL_EN       = 2;
    localparam int CTRL_DIR      = 3;

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler and step counter for the LED sequencer.
// Emits a combinational step strobe on the tick where count==period.
module led_tick_gen #(
    parameter int PRESC_DIV = 50000,
    parameter int PRESC_W   = 16
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic       in_clr,
    input  logic [7:0] in_period,
    output logic       out_step
);

    logic [PRESC_W-1:0] presc_q;
    logic [7:0]         cnt_q;
    logic               base_tick;
    logic               cnt_hit;

    assign base_tick = (presc_q == PRESC_W'(PRESC_DIV - 1));
    // >= so a shrinking PERIOD never forces a wrap through 255
    assign cnt_hit   = (cnt_q >= in_period);
    assign out_step  = !in_clr && base_tick && cnt_hit;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else if (in_clr) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else if (base_tick) begin
            presc_q <= '0;
            cnt_q   <= cnt_hit ? 8'd0 : cnt_q + 8'd1;
        end else begin
            presc_q <= presc_q + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// Register-programmed LED pattern sequencer: register file,
// IDLE/RUN FSM and pattern datapath driving the LED control word.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int LED_N     = 6,
    parameter int PRESC_DIV = 50000,
    parameter int PRESC_W   = 16
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_wr_en,
    input  logic             in_rd_en,
    input  logic [1:0]       in_addr,
    input  logic [7:0]       in_wdata,
    output logic [7:0]       out_rdata,
    output logic             out_rvalid,
    output logic [LED_N-1:0] out_mem,
    output logic             out_step
);

    logic [3:0]       ctrl_q;
    logic [LED_N-1:0] pattern_q;
    logic [7:0]       period_q;
    logic [LED_N-1:0] work_q, work_d, mem_d, pat_n;
    logic             phase_q, phase_d;
    state_e           state_q, state_d;
    mode_e            mode_q, mode_n;
    logic             ctrl_wr, pat_wr, per_wr;
    logic             load, step, clr;
    logic [7:0]       rd_mux;

    assign ctrl_wr = in_wr_en && (in_addr == ADDR_CTRL);
    assign pat_wr  = in_wr_en && (in_addr == ADDR_PATTERN);
    assign per_wr  = in_wr_en && (in_addr == ADDR_PERIOD);
    assign mode_q  = mode_e'(ctrl_q[CTRL_MODE_LSB+:2]);
    assign mode_n  = ctrl_wr ? mode_e'(in_wdata[CTRL_MODE_LSB+:2]) : mode_q;
    assign pat_n   = pat_wr ? in_wdata[LED_N-1:0] : pattern_q;
    assign clr     = (state_q != RUN) || load;

    led_tick_gen #(
        .PRESC_DIV (PRESC_DIV),
        .PRESC_W   (PRESC_W)
    ) u_tick (
        .in_clk    (in_clk),
        .in_rst    (in_rst),
        .in_clr    (clr),
        .in_period (period_q),
        .out_step  (step)
    );

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ctrl_wr && in_wdata[CTRL_EN]) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (ctrl_wr && !in_wdata[CTRL_EN]) begin
                    state_d = IDLE;
                end else if (ctrl_wr || pat_wr) begin
                    load = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        work_d  = work_q;
        phase_d = phase_q;
        mem_d   = '0;
        if (state_d == IDLE) begin
            work_d  = '0;
            phase_d = 1'b0;
        end else if (load) begin
            work_d  = (mode_n == MODE_COUNT) ? '0 : pat_n;
            phase_d = 1'b1;
        end else if (step) begin
            unique case (mode_q)
                MODE_BLINK: phase_d = !phase_q;
                MODE_CHASE: begin
                    if (ctrl_q[CTRL_DIR]) begin
                        work_d = {work_q[0], work_q[LED_N-1:1]};
                    end else begin
                        work_d = {work_q[LED_N-2:0], work_q[LED_N-1]};
                    end
                end
                MODE_COUNT: work_d = work_q + LED_N'(1);
                default: ;
            endcase
        end
        if (state_d == RUN) begin
            unique case (mode_n)
                MODE_STATIC: mem_d = pat_n;
                MODE_BLINK:  mem_d = phase_d ? pat_n : '0;
                default:     mem_d = work_d;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (in_addr)
            ADDR_CTRL:    rd_mux = {4'b0, ctrl_q};
            ADDR_PATTERN: rd_mux = 8'(pattern_q);
            ADDR_PERIOD:  rd_mux = period_q;
            ADDR_STATUS:  rd_mux = {phase_q, state_q == RUN, 6'(out_mem)};
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            ctrl_q     <= '0;
            pattern_q  <= '0;
            period_q   <= '0;
            work_q     <= '0;
            phase_q    <= 1'b0;
            out_mem    <= '0;
            out_step   <= 1'b0;
            out_rdata  <= '0;
            out_rvalid <= 1'b0;
        end else begin
            if (ctrl_wr) ctrl_q <= in_wdata[3:0];
            if (pat_wr)  pattern_q <= in_wdata[LED_N-1:0];
            if (per_wr)  period_q <= in_wdata;
            work_q     <= work_d;
            phase_q    <= phase_d;
            out_mem    <= mem_d;
            out_step   <= step;
            out_rvalid <= in_rd_en;
            out_rdata  <= in_rd_en ? rd_mux : 8'd0;
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with a short prescaler.
// Register table plus hand-built mode and corner sequences.
module tb_led_seq_ctrl;

    logic       in_clk = 1'b0;
    logic       in_rst, in_wr_en, in_rd_en;
    logic [1:0] in_addr;
    logic [7:0] in_wdata, out_rdata;
    logic       out_rvalid, out_step;
    logic [5:0] out_mem;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic       wr;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[7];
    int   exp_l[6] = '{'h02, 'h04, 'h08, 'h10, 'h20, 'h01};
    int   exp_r[6] = '{'h20, 'h10, 'h08, 'h04, 'h02, 'h01};

    always #5 in_clk = ~in_clk;

    led_seq_ctrl #(
        .LED_N     (6),
        .PRESC_DIV (4),
        .PRESC_W   (16)
    ) dut (
        .in_clk     (in_clk),
        .in_rst     (in_rst),
        .in_wr_en   (in_wr_en),
        .in_rd_en   (in_rd_en),
        .in_addr    (in_addr),
        .in_wdata   (in_wdata),
        .out_rdata  (out_rdata),
        .out_rvalid (out_rvalid),
        .out_mem    (out_mem),
        .out_step   (out_step)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge in_clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        in_wr_en = 1'b1;
        in_addr  = a;
        in_wdata = d;
        cyc();
        in_wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d,
                      output logic v);
        in_rd_en = 1'b1;
        in_addr  = a;
        cyc();
        in_rd_en = 1'b0;
        d = out_rdata;
        v = out_rvalid;
    endtask

    task automatic wait_step(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!out_step && n < 100);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        logic [7:0] d;
        logic       v;

        vt[0] = '{1'b1, 2'd0, 8'h0B, 8'h0B};
        vt[1] = '{1'b1, 2'd0, 8'hF3, 8'h03};
        vt[2] = '{1'b1, 2'd1, 8'hFF, 8'h3F};
        vt[3] = '{1'b1, 2'd1, 8'h2D, 8'h2D};
        vt[4] = '{1'b1, 2'd2, 8'h55, 8'h55};
        vt[5] = '{1'b1, 2'd3, 8'hFF, 8'h00};
        vt[6] = '{1'b0, 2'd2, 8'h00, 8'h55};

        in_rst   = 1'b1;
        in_wr_en = 1'b0;
        in_rd_en = 1'b0;
        in_addr  = 2'd0;
        in_wdata = 8'h00;
        repeat (2) cyc();
        chk("reset mem", out_mem, 0);
        chk("reset step", out_step, 0);
        chk("reset rvalid", out_rvalid, 0);
        chk("reset rdata", out_rdata, 0);
        in_rst = 1'b0;
        cyc();

        for (int i = 0; i < 7; i++) begin
            if (vt[i].wr) wr(vt[i].addr, vt[i].wdata);
            rd(vt[i].addr, d, v);
            chk($sformatf("reg%0d rvalid", i), v, 1);
            chk($sformatf("reg%0d rdata", i), d, vt[i].exp);
            cyc();
            chk($sformatf("reg%0d rvalid drop", i), out_rvalid, 0);
        end
        chk("idle mem", out_mem, 0);

        in_rd_en = 1'b1;
        in_wr_en = 1'b1;
        in_addr  = 2'd2;
        in_wdata = 8'h12;
        cyc();
        in_rd_en = 1'b0;
        in_wr_en = 1'b0;
        chk("rd/wr pre-value", out_rdata, 'h55);
        rd(2'd2, d, v);
        chk("rd/wr post-value", d, 'h12);

        wr(2'd2, 8'h00);
        wr(2'd1, 8'h2D);
        wr(2'd0, 8'h04);
        chk("static entry", out_mem, 'h2D);
        wait_step(n);
        chk("static step gap", n, 4);
        chk("static mem", out_mem, 'h2D);
        cyc();
        chk("step width", out_step, 0);
        wait_step(n);
        chk("static step gap2", n, 3);
        rd(2'd3, d, v);
        chk("static status", d, 'hED);

        wr(2'd0, 8'h00);
        chk("run->idle mem", out_mem, 0);
        rd(2'd3, d, v);
        chk("idle status", d, 'h00);

        wr(2'd2, 8'h01);
        wr(2'd1, 8'h3F);
        wr(2'd0, 8'h05);
        chk("blink entry", out_mem, 'h3F);
        rd(2'd3, d, v);
        chk("blink status ph1", d, 'hFF);
        wait_step(n);
        chk("blink gap1", n, 7);
        chk("blink off", out_mem, 'h00);
        rd(2'd3, d, v);
        chk("blink status ph0", d, 'h40);
        wait_step(n);
        chk("blink gap2", n, 7);
        chk("blink on", out_mem, 'h3F);
        wait_step(n);
        chk("blink gap3", n, 8);
        chk("blink off2", out_mem, 'h00);

        wr(2'd0, 8'h00);
        wr(2'd2, 8'h00);
        wr(2'd1, 8'h01);
        wr(2'd0, 8'h06);
        chk("chase entry", out_mem, 'h01);
        for (int i = 0; i < 6; i++) begin
            wait_step(n);
            chk($sformatf("chase L gap%0d", i), n, 4);
            chk($sformatf("chase L%0d", i), out_mem, exp_l[i]);
        end
        wr(2'd0, 8'h0E);
        chk("chase R reload", out_mem, 'h01);
        for (int i = 0; i < 6; i++) begin
            wait_step(n);
            chk($sformatf("chase R%0d", i), out_mem, exp_r[i]);
        end

        wr(2'd0, 8'h07);
        chk("count entry", out_mem, 0);
        for (int i = 1; i < 64; i++) begin
            wait_step(n);
            chk($sformatf("count %0d", i), out_mem, i);
        end
        wait_step(n);
        chk("count wrap", out_mem, 0);
        repeat (3) cyc();
        wr(2'd1, 8'h2A);
        chk("write wins step", out_step, 0);
        chk("write wins mem", out_mem, 0);
        wait_step(n);
        chk("restart gap", n, 4);
        chk("restart mem", out_mem, 1);

        in_rd_en = 1'b1;
        in_addr  = 2'd3;
        cyc();
        in_rd_en = 1'b0;
        chk("pre-reset rvalid", out_rvalid, 1);
        #2;
        in_rst = 1'b1;
        #1;
        chk("async rst mem", out_mem, 0);
        chk("async rst rvalid", out_rvalid, 0);
        chk("async rst step", out_step, 0);
        cyc();
        in_rst = 1'b0;
        rd(2'd3, d, v);
        chk("post-reset status", d, 'h00);
        rd(2'd2, d, v);
        chk("post-reset period", d, 'h00);
        rd(2'd0, d, v);
        chk("post-reset ctrl", d, 'h00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Register-programmed pattern sequencer. Produces the 6-bit LED control word that feeds the LED output register stage.
- Supports four modes: static, blink, chase and binary count. Step rate comes from a prescaler and a programmable period.
- Sits between the host register bus and the LED output stage, and is the only writer of the LED control word.

Parameters:
- LED_N, 6, number of LEDs (width of pattern/output)
- PRESC_DIV, 50000, in_clk cycles per base tick (≥2)
- PRESC_W, 16, prescaler counter width (must hold PRESC_DIV-1)

Ports:
- in_clk  in  1  system clock
- in_rst  in  1  reset, asynchronous, active-high
- in_wr_en  in  1  register write strobe, one cycle
- in_rd_en  in  1  register read strobe, one cycle
- in_addr  in  2  register address
- in_wdata  in  8  write data
- out_rdata  out  8  read data, valid when out_rvalid=1
- out_rvalid  out  1  read response strobe
- out_mem  out  LED_N  LED control word to the output stage
- out_step  out  1  one-cycle pulse on each pattern step

Behaviour:
- Reset (async, in_rst=1):
  - all registers 0; FSM=IDLE
  - out_mem=0, out_step=0, out_rdata=0, out_rvalid=0
- Register map:
  - 0 CTRL: [1:0] mode (00 STATIC, 01 BLINK, 10 CHASE, 11 COUNT), [2] enable, [3] dir (0=left/MSB-ward, 1=right)
  - 1 PATTERN: [LED_N-1:0]
  - 2 PERIOD: [7:0], step every PERIOD+1 base ticks
  - 3 STATUS: read-only; [5:0]=out_mem, [6]=FSM==RUN, [7]=blink phase; writes ignored
- Reads: out_rdata/out_rvalid registered, latency 1 cycle; unused bits read 0. Simultaneous rd and wr to the same address returns the pre-write value.
- Prescaler: counts 0..PRESC_DIV-1 while RUN; base tick on the wrap.
- Step counter: counts base ticks 0..PERIOD. On a tick with count==PERIOD: step (count←0, out_step=1 for that cycle).
- FSM states:
  - IDLE: enable=0; prescaler, step counter, work register and phase held at 0; out_mem=0.
  - IDLE→RUN: on the cycle after enable is written 1. Work register←PATTERN (COUNT mode: ←0); phase←1; out_mem←work next cycle.
  - RUN→IDLE: enable written 0; out_mem=0 next cycle.
- Mode behaviour on each step:
  - STATIC: out_mem=PATTERN continuously; steps still pulse out_step.
  - BLINK: phase toggles; out_mem=PATTERN when phase=1, else 0.
  - CHASE: work rotates by 1 (dir); out_mem=work. Pattern 0 stays 0.
  - COUNT: work increments modulo 2^LED_N (63→0); out_mem=work.
- Reload: any write to CTRL or PATTERN while RUN clears the prescaler and step counter, reloads work/phase as on entry, and suppresses a coincident step (write wins). A PERIOD write takes effect at the next compare; no reload.
- PERIOD=0: one step per base tick.
- out_mem is registered and changes only on a step, reload or state change. A new in_rst assertion mid-operation forces everything to reset values immediately.

Decomposition:
- Package led_seq_pkg:
  - mode enum (MODE_STATIC/BLINK/CHASE/COUNT)
  - address constants ADDR_CTRL/PATTERN/PERIOD/STATUS
  - FSM state enum (IDLE/RUN)
  - CTRL bit-index constants
- Sub-module led_tick_gen: prescaler plus step counter, with clear input, PERIOD input, step output. Top holds the register file, FSM and pattern datapath.

Test Plan (bench uses PRESC_DIV=4):
- Reset mid-RUN: assert in_rst async between clock edges → out_mem, out_step, out_rvalid go 0 at once; STATUS reads 0x00 after release.
- Static: PATTERN=0x2D, CTRL=0x04 → out_mem=0x2D one cycle after CTRL write; out_step pulses every 4 cycles (PERIOD=0).
- Blink: PATTERN=0x3F, PERIOD=1, CTRL=0x05 → out_mem alternates 0x3F/0x00 every 8 cycles; STATUS[7] tracks phase.
- Chase: PATTERN=0x01, CTRL=0x06 → out_mem 0x01,0x02,…,0x20,0x01. With CTRL=0x0E from 0x01 → 0x20,0x10,… (right rotation).
- Count wrap and write-wins: CTRL=0x07 runs to 0x3F, then 0x00. A PATTERN write on the same cycle as a step → no step pulse, counters cleared, out_mem=0x00 on restart.
- Read/write: write 0x55 to PERIOD, read addr 2 → out_rdata=0x55 with out_rvalid exactly one cycle after in_rd_en. A write to STATUS leaves STATUS unchanged.
